spi_mem_arbiter: RTL and testbench

Arbiter and sequencer in front of the shared SPI flash/PSRAM controller. Accepts instruction-fetch requests (16-bit flash reads) and data requests (8-bit PSRAM read/write) over req/ack handshakes, and grants one at a time. It drives the controller's command inputs and returns read data to the winning requester. A one-entry fetch buffer answers repeated fetches of the same word without SPI traffic; a streak counter keeps data traffic from starving fetch.

---
 rtl/spi_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: req/ack arbiter and sequencer in front of the shared SPI flash/PSRAM controller.
// Ports: clk_in/reset_n_in (async active-low); imem_* fetch port (16-bit flash words, one-entry
// fetch buffer); dmem_* data port (8-bit PSRAM read/write); ctl_* command outputs to the
// controller and its data/valid/busy returns. STARVE_LIMIT bounds consecutive data grants
// while a fetch is waiting.
package spi_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        TYPE_IMEM_READ  = 2'd0,
        TYPE_DMEM_READ  = 2'd1,
        TYPE_DMEM_WRITE = 2'd2
    } mem_type_t;
endpackage

module spi_mem_arbiter
    import spi_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        imem_req_in,
    input  logic [15:0] imem_addr_in,
    output logic        imem_ack_out,
    output logic [15:0] imem_data_out,
    input  logic        dmem_req_in,
    input  logic        dmem_we_in,
    input  logic [15:0] dmem_addr_in,
    input  logic [7:0]  dmem_wdata_in,
    output logic        dmem_ack_out,
    output logic [7:0]  dmem_rdata_out,
    output logic [15:0] ctl_addr_out,
    output logic        ctl_addr_valid_out,
    output mem_type_t   ctl_mem_type_out,
    output logic [7:0]  ctl_wdata_out,
    input  logic [15:0] ctl_flash_data_in,
    input  logic        ctl_flash_valid_in,
    input  logic [7:0]  ctl_psram_data_in,
    input  logic        ctl_psram_valid_in,
    input  logic        ctl_busy_in
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        buf_valid_q, buf_valid_d;
    logic [14:0] buf_addr_q, buf_addr_d;
    logic [15:0] buf_data_q, buf_data_d;
    logic [15:0] addr_q, addr_d;
    mem_type_t   type_q, type_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [15:0] idata_q, idata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        iack_q, iack_d;
    logic        dack_q, dack_d;
    logic        grant_i, hit;

    assign grant_i = imem_req_in && (!dmem_req_in || streak_q == 4'(STARVE_LIMIT));
    assign hit     = buf_valid_q && buf_addr_q == imem_addr_in[15:1];

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        addr_d      = addr_q;
        type_d      = type_q;
        wdata_d     = wdata_q;
        valid_d     = 1'b0;
        idata_d     = idata_q;
        rdata_d     = rdata_q;
        iack_d      = 1'b0;
        dack_d      = 1'b0;
        case (state_q)
            IDLE: if (!ctl_busy_in && (imem_req_in || dmem_req_in)) begin
                if (grant_i) begin
                    streak_d = '0;
                    if (hit) begin
                        idata_d = buf_data_q;
                        iack_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d  = imem_addr_in;
                        type_d  = TYPE_IMEM_READ;
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    // A data grant with a fetch waiting implies streak < limit, so this saturates.
                    if (imem_req_in) streak_d = streak_q + 4'd1;
                    addr_d  = dmem_addr_in;
                    type_d  = dmem_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
                    wdata_d = dmem_wdata_in;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: if (type_q == TYPE_IMEM_READ) begin
                if (ctl_flash_valid_in) begin
                    idata_d     = ctl_flash_data_in;
                    buf_data_d  = ctl_flash_data_in;
                    buf_addr_d  = addr_q[15:1];
                    buf_valid_d = 1'b1;
                    iack_d      = 1'b1;
                    state_d     = RESP;
                end
            end else if (type_q == TYPE_DMEM_READ) begin
                if (ctl_psram_valid_in) begin
                    rdata_d = ctl_psram_data_in;
                    dack_d  = 1'b1;
                    state_d = RESP;
                end
            end else if (!ctl_busy_in) begin
                dack_d  = 1'b1;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            addr_q      <= '0;
            type_q      <= TYPE_IMEM_READ;
            wdata_q     <= '0;
            valid_q     <= 1'b0;
            idata_q     <= '0;
            rdata_q     <= '0;
            iack_q      <= 1'b0;
            dack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            addr_q      <= addr_d;
            type_q      <= type_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
            idata_q     <= idata_d;
            rdata_q     <= rdata_d;
            iack_q      <= iack_d;
            dack_q      <= dack_d;
        end
    end

    assign imem_ack_out       = iack_q;
    assign imem_data_out      = idata_q;
    assign dmem_ack_out       = dack_q;
    assign dmem_rdata_out     = rdata_q;
    assign ctl_addr_out       = addr_q;
    assign ctl_addr_valid_out = valid_q;
    assign ctl_mem_type_out   = type_q;
    assign ctl_wdata_out      = wdata_q;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: self-checking bench for spi_mem_arbiter with a cycle-timed SPI controller
// model and a transaction-level reference model of grants, latencies, fetch buffer and PSRAM.
module tb_spi_mem_arbiter;
    import spi_mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        imem_req_in = 1'b0;
    logic [15:0] imem_addr_in = '0;
    logic        imem_ack_out;
    logic [15:0] imem_data_out;
    logic        dmem_req_in = 1'b0;
    logic        dmem_we_in = 1'b0;
    logic [15:0] dmem_addr_in = '0;
    logic [7:0]  dmem_wdata_in = '0;
    logic        dmem_ack_out;
    logic [7:0]  dmem_rdata_out;
    logic [15:0] ctl_addr_out;
    logic        ctl_addr_valid_out;
    mem_type_t   ctl_mem_type_out;
    logic [7:0]  ctl_wdata_out;
    logic [15:0] ctl_flash_data_in = '0;
    logic        ctl_flash_valid_in = 1'b0;
    logic [7:0]  ctl_psram_data_in = '0;
    logic        ctl_psram_valid_in = 1'b0;
    logic        ctl_busy_in;

    always #5 clk_in = ~clk_in;

    spi_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .imem_req_in(imem_req_in), .imem_addr_in(imem_addr_in),
        .imem_ack_out(imem_ack_out), .imem_data_out(imem_data_out),
        .dmem_req_in(dmem_req_in), .dmem_we_in(dmem_we_in), .dmem_addr_in(dmem_addr_in),
        .dmem_wdata_in(dmem_wdata_in), .dmem_ack_out(dmem_ack_out), .dmem_rdata_out(dmem_rdata_out),
        .ctl_addr_out(ctl_addr_out), .ctl_addr_valid_out(ctl_addr_valid_out),
        .ctl_mem_type_out(ctl_mem_type_out), .ctl_wdata_out(ctl_wdata_out),
        .ctl_flash_data_in(ctl_flash_data_in), .ctl_flash_valid_in(ctl_flash_valid_in),
        .ctl_psram_data_in(ctl_psram_data_in), .ctl_psram_valid_in(ctl_psram_valid_in),
        .ctl_busy_in(ctl_busy_in)
    );

    function automatic logic [7:0] flash_byte(input logic [15:0] a);
        return a == 16'h0040 ? 8'h12 : a == 16'h0041 ? 8'h34 : a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Controller model: latches the command in the ISSUE cycle, busy until done,
    // flash valid 96 cycles after ISSUE, PSRAM read valid after 80, write idle after 81.
    logic       busy_dev = 1'b0, busy_force = 1'b0;
    logic       dactive = 1'b0;
    int         dcnt = 0;
    logic [15:0] daddr;
    mem_type_t  dtype;
    logic [7:0] dwd;
    logic [7:0] dev_psram [0:255];
    assign ctl_busy_in = busy_dev | busy_force;

    always @(negedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            dactive = 1'b0; busy_dev = 1'b0; dcnt = 0;
            ctl_flash_valid_in = 1'b0; ctl_psram_valid_in = 1'b0;
        end else begin
            ctl_flash_valid_in = 1'b0;
            ctl_psram_valid_in = 1'b0;
            if (ctl_addr_valid_out) begin
                dactive = 1'b1; dcnt = 0;
                daddr = ctl_addr_out; dtype = ctl_mem_type_out; dwd = ctl_wdata_out;
            end else if (dactive) begin
                dcnt++;
                if (dtype == TYPE_IMEM_READ && dcnt == 96) begin
                    ctl_flash_data_in = {flash_byte({daddr[15:1], 1'b0}), flash_byte({daddr[15:1], 1'b1})};
                    ctl_flash_valid_in = 1'b1; dactive = 1'b0;
                end else if (dtype == TYPE_DMEM_READ && dcnt == 80) begin
                    ctl_psram_data_in = dev_psram[daddr[7:0]];
                    ctl_psram_valid_in = 1'b1; dactive = 1'b0;
                end else if (dtype == TYPE_DMEM_WRITE && dcnt == 81) begin
                    dev_psram[daddr[7:0]] = dwd; dactive = 1'b0;
                end
            end
            busy_dev = dactive;
        end
    end

    // Reference model state
    logic [7:0]  ref_psram [0:255];
    bit          ref_buf_v = 1'b0;
    logic [15:0] ref_buf_a = '0;
    int          streak = 0;

    typedef struct {bit we; logic [15:0] a; logic [7:0] wd;} dtx_t;
    dtx_t  dq[$];
    string order;
    int    checks = 0, errors = 0;

    // Raises an optional fetch plus the queued data transactions (data re-raised right after
    // each ack), optionally holding the controller busy first, and checks every grant.
    task automatic run_round(input bit want_i, input logic [15:0] ia, input int hold);
        bit pi, pd, win_i, exp_issue, bad;
        int n, off, issues, exp_lat;
        logic [15:0] exp_addr, exp_idata, seen_addr;
        logic [7:0] exp_rd;
        mem_type_t exp_type, seen_type;
        dtx_t cur;
        cur = '{0, 16'h0, 8'h0};
        exp_rd = '0; exp_idata = '0; seen_addr = '0; seen_type = TYPE_IMEM_READ;
        order = "";
        bad = 0;
        @(negedge clk_in);
        checks++;
        if (imem_ack_out !== 1'b0 || dmem_ack_out !== 1'b0) begin
            errors++; $display("FAIL idle_ack: imem_ack=%b dmem_ack=%b, required 0 0", imem_ack_out, dmem_ack_out);
        end
        pi = want_i;
        pd = dq.size() > 0;
        if (pd) cur = dq.pop_front();
        imem_req_in = pi; imem_addr_in = ia;
        dmem_req_in = pd; dmem_we_in = cur.we; dmem_addr_in = cur.a; dmem_wdata_in = cur.wd;
        busy_force = hold > 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk_in);
            checks++;
            if (ctl_addr_valid_out !== 1'b0 || imem_ack_out !== 1'b0 || dmem_ack_out !== 1'b0) begin
                errors++; $display("FAIL busy_hold: valid=%b iack=%b dack=%b, required all 0", ctl_addr_valid_out, imem_ack_out, dmem_ack_out);
            end
        end
        busy_force = 1'b0;
        n = 0; off = 0;
        while ((pi || pd) && !bad) begin
            win_i = pi && (!pd || streak == LIMIT);
            if (win_i) begin
                streak = 0;
                exp_issue = !(ref_buf_v && ref_buf_a == {ia[15:1], 1'b0});
                exp_lat = exp_issue ? 98 : 1;
                exp_idata = {flash_byte({ia[15:1], 1'b0}), flash_byte({ia[15:1], 1'b1})};
                exp_addr = ia; exp_type = TYPE_IMEM_READ;
                ref_buf_v = 1'b1; ref_buf_a = {ia[15:1], 1'b0};
            end else begin
                if (pi) streak = streak < LIMIT ? streak + 1 : streak;
                exp_issue = 1'b1;
                exp_lat = cur.we ? 83 : 82;
                exp_rd = ref_psram[cur.a[7:0]];
                exp_addr = cur.a; exp_type = cur.we ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
                if (cur.we) ref_psram[cur.a[7:0]] = cur.wd;
            end
            issues = 0;
            forever begin
                @(negedge clk_in);
                n++;
                if (ctl_addr_valid_out) begin
                    issues++; seen_addr = ctl_addr_out; seen_type = ctl_mem_type_out;
                    checks++;
                    if (n != 1 + off) begin errors++; $display("FAIL issue_time: cycle %0d, required %0d", n, 1 + off); end
                end
                if (imem_ack_out || dmem_ack_out) break;
                if (n > exp_lat + off + 20) begin bad = 1; break; end
            end
            checks++;
            if (bad) begin
                errors++; $display("FAIL ack_timeout: no ack after %0d cycles, required at %0d", n, exp_lat + off);
                break;
            end
            if (imem_ack_out !== win_i || dmem_ack_out !== !win_i) begin
                errors++; $display("FAIL grant: iack=%b dack=%b, required iack=%b", imem_ack_out, dmem_ack_out, win_i);
            end
            checks++;
            if (n != exp_lat + off) begin errors++; $display("FAIL latency: ack at %0d, required %0d", n, exp_lat + off); end
            checks++;
            if (issues != int'(exp_issue)) begin errors++; $display("FAIL issue_count: %0d issues, required %0d", issues, exp_issue); end
            if (exp_issue) begin
                checks++;
                if (seen_addr !== exp_addr || seen_type !== exp_type) begin
                    errors++; $display("FAIL issue_cmd: addr=%h type=%0d, required addr=%h type=%0d", seen_addr, seen_type, exp_addr, exp_type);
                end
            end
            if (win_i) begin
                checks++;
                if (imem_data_out !== exp_idata) begin errors++; $display("FAIL imem_data: %h, required %h", imem_data_out, exp_idata); end
            end else if (!cur.we) begin
                checks++;
                if (dmem_rdata_out !== exp_rd) begin errors++; $display("FAIL dmem_rdata: %h, required %h", dmem_rdata_out, exp_rd); end
            end
            order = {order, win_i ? "I" : "D"};
            if (win_i) begin
                pi = 0; imem_req_in = 1'b0;
            end else if (dq.size() > 0) begin
                cur = dq.pop_front();
                dmem_we_in = cur.we; dmem_addr_in = cur.a; dmem_wdata_in = cur.wd;
            end else begin
                pd = 0; dmem_req_in = 1'b0;
            end
            n = 0; off = 1;
        end
        if (bad) begin
            imem_req_in = 1'b0; dmem_req_in = 1'b0; dq.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (imem_ack_out !== 1'b0 || dmem_ack_out !== 1'b0 || ctl_addr_valid_out !== 1'b0 ||
            ctl_addr_out !== 16'h0 || ctl_wdata_out !== 8'h0 || imem_data_out !== 16'h0 ||
            dmem_rdata_out !== 8'h0 || ctl_mem_type_out !== TYPE_IMEM_READ) begin
            errors++;
            $display("FAIL %s: iack=%b dack=%b valid=%b addr=%h wdata=%h idata=%h rdata=%h type=%0d, required all 0",
                     name, imem_ack_out, dmem_ack_out, ctl_addr_valid_out, ctl_addr_out, ctl_wdata_out,
                     imem_data_out, dmem_rdata_out, ctl_mem_type_out);
        end
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset_held");
        reset_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check_outputs_zero("reset_released");
    endtask

    task automatic test_fetch_miss_hit();
        run_round(1'b1, 16'h0041, 0);
        checks++;
        if (imem_data_out !== 16'h1234) begin errors++; $display("FAIL miss_data: %h, required 1234", imem_data_out); end
        run_round(1'b1, 16'h0040, 0);
        checks++;
        if (imem_data_out !== 16'h1234) begin errors++; $display("FAIL hit_data: %h, required 1234", imem_data_out); end
    endtask

    task automatic test_write_read();
        dq.push_back('{1'b1, 16'h0100, 8'hA5});
        dq.push_back('{1'b0, 16'h0100, 8'h00});
        run_round(1'b0, 16'h0, 0);
        checks++;
        if (dmem_rdata_out !== 8'hA5) begin errors++; $display("FAIL write_read: rdata %h, required a5", dmem_rdata_out); end
    endtask

    task automatic test_simultaneous();
        dq.push_back('{1'b0, 16'h0101, 8'h00});
        run_round(1'b1, 16'h0300, 0);
        checks++;
        if (order != "DI") begin errors++; $display("FAIL simultaneous_order: %s, required DI", order); end
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 6; k++)
            dq.push_back('{1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), 8'($urandom)});
        run_round(1'b1, 16'h0500, 0);
        checks++;
        if (order != "DDDDIDD") begin errors++; $display("FAIL starve_order: %s, required DDDDIDD", order); end
        dq.push_back('{1'b0, 16'h0103, 8'h00});
        run_round(1'b1, 16'h0502, 0);
        checks++;
        if (order != "DI") begin errors++; $display("FAIL streak_cleared: %s, required DI", order); end
    endtask

    task automatic test_busy();
        dq.push_back('{1'b0, 16'h0102, 8'h00});
        run_round(1'b1, 16'h0041, 10);
    endtask

    task automatic test_reset_mid_fetch();
        int acks;
        run_round(1'b1, 16'h2002, 0);
        @(negedge clk_in);
        imem_req_in = 1'b1; imem_addr_in = 16'h3000;
        acks = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (imem_ack_out || dmem_ack_out) acks++;
        end
        reset_n_in = 1'b0;
        #1;
        check_outputs_zero("reset_mid_fetch");
        imem_req_in = 1'b0;
        ref_buf_v = 1'b0; streak = 0;
        repeat (3) @(negedge clk_in);
        reset_n_in = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            if (imem_ack_out || dmem_ack_out) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL reset_no_ack: %0d acks, required 0", acks); end
        run_round(1'b1, 16'h2002, 0);
    endtask

    task automatic test_random();
        bit wi;
        int nd;
        for (int r = 0; r < 30; r++) begin
            wi = 1'($urandom_range(0, 1));
            nd = $urandom_range(0, 3);
            if (!wi && nd == 0) nd = 1;
            for (int k = 0; k < nd; k++)
                dq.push_back('{1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), 8'($urandom)});
            run_round(wi, 16'h0040 + 16'($urandom_range(0, 7)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            dev_psram[k] = 8'h00;
            ref_psram[k] = 8'h00;
        end
        test_reset();
        test_fetch_miss_hit();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_busy();
        test_reset_mid_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
